dffram_arbiter: RTL and testbench

DFFRAM_ARBITER -- requirements
Module: dffram_arbiter

---
 rtl/dffram_arbiter.sv | 129 ++++++++++++
 tb/tb_dffram_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dffram_arbiter.sv
// rtl/dffram_arbiter.sv - two-port round-robin arbiter in front of a single-port DFFRAM
//
// Purpose: serialises word accesses from two requesters onto one DFFRAM port.
// Each granted access spends one cycle in ACCESS (RAM enabled) and one in
// RESP (ack pulse, read data returned). The RAM is read-before-write, so a
// write is acked with the word's previous contents.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   pN_req              request, held until acked
//   pN_we               byte write enables (0 = read)
//   pN_a, pN_di         word address, write data
//   pN_ack, pN_do       one-cycle completion pulse, read data (0 when not acked)
//   ram_en, ram_we      RAM enable / byte write enables, high only in ACCESS
//   ram_a, ram_di       RAM address / write data, hold last granted values
//   ram_do              RAM read data, 1-cycle latency, 0 when EN was low
module dffram_arbiter #(
  parameter int COLS = 1,
  localparam int A_WIDTH = 8 + $clog2(COLS)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               p0_req,
  input  logic [3:0]         p0_we,
  input  logic [A_WIDTH-1:0] p0_a,
  input  logic [31:0]        p0_di,
  output logic               p0_ack,
  output logic [31:0]        p0_do,
  input  logic               p1_req,
  input  logic [3:0]         p1_we,
  input  logic [A_WIDTH-1:0] p1_a,
  input  logic [31:0]        p1_di,
  output logic               p1_ack,
  output logic [31:0]        p1_do,
  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [A_WIDTH-1:0] ram_a,
  output logic [31:0]        ram_di,
  input  logic [31:0]        ram_do
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0] state;
  // Port of the current/most recent grant; doubles as the round-robin
  // pointer. Resets to 1 so that port 0 wins the first contention.
  logic       gnt;

  logic       grant;
  logic       sel;

  // Arbitration happens in IDLE and in RESP. In RESP only the port that is
  // not being acked may be granted, because the acked port's req is still
  // the old request during its own ack cycle.
  always_comb begin
    grant = 1'b0;
    sel   = 1'b0;
    case (state)
      IDLE: begin
        if (p0_req && p1_req) begin
          grant = 1'b1;
          sel   = ~gnt;
        end else if (p0_req) begin
          grant = 1'b1;
          sel   = 1'b0;
        end else if (p1_req) begin
          grant = 1'b1;
          sel   = 1'b1;
        end
      end
      RESP: begin
        if (gnt == 1'b1 && p0_req) begin
          grant = 1'b1;
          sel   = 1'b0;
        end else if (gnt == 1'b0 && p1_req) begin
          grant = 1'b1;
          sel   = 1'b1;
        end
      end
      default: begin
        grant = 1'b0;
        sel   = 1'b0;
      end
    endcase
  end

  // A grant always leads to ACCESS, so ram_en is simply the registered grant
  // and the RAM-side outputs come straight from flops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      gnt    <= 1'b1;
      ram_en <= 1'b0;
      ram_we <= 4'b0;
      ram_a  <= '0;
      ram_di <= 32'h0;
    end else begin
      if (grant) begin
        state <= ACCESS;
      end else if (state == ACCESS) begin
        state <= RESP;
      end else begin
        state <= IDLE;
      end

      ram_en <= grant;
      if (grant) begin
        gnt    <= sel;
        ram_we <= sel ? p1_we : p0_we;
        ram_a  <= sel ? p1_a  : p0_a;
        ram_di <= sel ? p1_di : p0_di;
      end else begin
        ram_we <= 4'b0;
      end
    end
  end

  // Ack and data are decoded from the state register, so reset clears them
  // immediately along with the state.
  always_comb begin
    p0_ack = (state == RESP) && (gnt == 1'b0);
    p1_ack = (state == RESP) && (gnt == 1'b1);
    p0_do  = p0_ack ? ram_do : 32'h0;
    p1_do  = p1_ack ? ram_do : 32'h0;
  end

endmodule

// File: tb/tb_dffram_arbiter.sv
// tb/tb_dffram_arbiter.sv - self-checking bench for dffram_arbiter
//
// Purpose: drives dffram_arbiter against a behavioural read-before-write
// DFFRAM model with a table of single-port transactions and directed
// sequences for contention, back-to-back, mid-operation reset and a
// withdrawn request.
// Ports: none (top-level bench).
module tb_dffram_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        p0_req, p1_req;
  logic [3:0]  p0_we, p1_we;
  logic [7:0]  p0_a, p1_a;
  logic [31:0] p0_di, p1_di;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_do, p1_do;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [7:0]  ram_a;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  int checks = 0;
  int errors = 0;

  dffram_arbiter #(.COLS(1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .p0_req(p0_req), .p0_we(p0_we), .p0_a(p0_a), .p0_di(p0_di),
    .p0_ack(p0_ack), .p0_do(p0_do),
    .p1_req(p1_req), .p1_we(p1_we), .p1_a(p1_a), .p1_di(p1_di),
    .p1_ack(p1_ack), .p1_do(p1_do),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Read-before-write RAM model; contents are loaded on the first edge
  // (which always falls inside reset).
  logic [31:0] mem [0:255];
  bit          init_done = 1'b0;

  always @(posedge CLK) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[1]   <= 32'h0000_0111;
      mem[2]   <= 32'h0000_0222;
      mem[5]   <= 32'hDEAD_BEEF;
      mem[255] <= 32'hA5A5_A5A5;
      ram_do   <= 32'h0;
      init_done <= 1'b1;
    end else if (ram_en) begin
      ram_do <= mem[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
    end else begin
      ram_do <= 32'h0;
    end
  end

  typedef struct {
    bit          port;
    logic [3:0]  we;
    logic [7:0]  a;
    logic [31:0] di;
    logic [31:0] exp_do;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 4'h0; p0_a = 8'h0; p0_di = 32'h0;
    p1_req = 0; p1_we = 4'h0; p1_a = 8'h0; p1_di = 32'h0;
  endtask

  initial begin
    RST_N = 1'b0;
    idle_inputs();

    vecs[0] = '{1'b0, 4'b0000, 8'd5,   32'h0000_0000, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 4'b0010, 8'd9,   32'h0000_AB00, 32'h0000_0000};
    vecs[2] = '{1'b0, 4'b0000, 8'd9,   32'h0000_0000, 32'h0000_AB00};
    vecs[3] = '{1'b1, 4'b0000, 8'd9,   32'h0000_0000, 32'h0000_AB00};
    vecs[4] = '{1'b0, 4'b1111, 8'd255, 32'h1234_5678, 32'hA5A5_A5A5};
    vecs[5] = '{1'b1, 4'b0000, 8'd255, 32'h0000_0000, 32'h1234_5678};
    vecs[6] = '{1'b0, 4'b1001, 8'd5,   32'h1122_3344, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 4'b0000, 8'd5,   32'h0000_0000, 32'h11AD_BE44};

    // Reset state, with a request pending that must not be served yet
    p0_req = 1'b1;
    tick(); tick();
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_a",  32'(ram_a),  32'h0);
    chk("rst_ram_di", ram_di,      32'h0);
    chk("rst_acks",   {30'h0, p1_ack, p0_ack}, 32'h0);
    chk("rst_dos",    p0_do | p1_do, 32'h0);
    p0_req = 1'b0;
    RST_N  = 1'b1;
    tick();
    chk("idle_ram_en", 32'(ram_en), 32'h0);

    // Single-port transactions; the idle port carries junk that must be ignored
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].port == 1'b0) begin
        p0_req = 1; p0_we = vecs[i].we; p0_a = vecs[i].a; p0_di = vecs[i].di;
        p1_req = 0; p1_we = 4'hF; p1_a = 8'hAA; p1_di = 32'hFFFF_FFFF;
      end else begin
        p1_req = 1; p1_we = vecs[i].we; p1_a = vecs[i].a; p1_di = vecs[i].di;
        p0_req = 0; p0_we = 4'hF; p0_a = 8'hAA; p0_di = 32'hFFFF_FFFF;
      end
      tick();
      chk($sformatf("v%0d_acc_en", i), 32'(ram_en), 32'h1);
      chk($sformatf("v%0d_acc_a", i),  32'(ram_a),  32'(vecs[i].a));
      chk($sformatf("v%0d_acc_we", i), 32'(ram_we), 32'(vecs[i].we));
      chk($sformatf("v%0d_acc_di", i), ram_di,      vecs[i].di);
      chk($sformatf("v%0d_acc_ack", i), {30'h0, p1_ack, p0_ack}, 32'h0);
      tick();
      chk($sformatf("v%0d_resp_ack", i), {30'h0, p1_ack, p0_ack},
          vecs[i].port ? 32'h2 : 32'h1);
      chk($sformatf("v%0d_resp_do", i), vecs[i].port ? p1_do : p0_do, vecs[i].exp_do);
      chk($sformatf("v%0d_resp_other_do", i), vecs[i].port ? p0_do : p1_do, 32'h0);
      chk($sformatf("v%0d_resp_en", i), {27'h0, ram_we, ram_en}, 32'h0);
      chk($sformatf("v%0d_resp_a_hold", i), 32'(ram_a), 32'(vecs[i].a));
      idle_inputs();
      tick();
      chk($sformatf("v%0d_after_ack", i), {30'h0, p1_ack, p0_ack}, 32'h0);
    end

    // Contention from reset release: p0, p1, p0, p1 with acks 2 cycles apart
    RST_N = 1'b0;
    p0_req = 1; p0_a = 8'd1;
    p1_req = 1; p1_a = 8'd2;
    tick();
    RST_N = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c % 2 == 1) begin
        chk($sformatf("cont%0d_en", c), 32'(ram_en), 32'h1);
        chk($sformatf("cont%0d_a", c), 32'(ram_a), ((c % 4) == 1) ? 32'd1 : 32'd2);
        chk($sformatf("cont%0d_noack", c), {30'h0, p1_ack, p0_ack}, 32'h0);
      end else begin
        chk($sformatf("cont%0d_en", c), 32'(ram_en), 32'h0);
        chk($sformatf("cont%0d_ack", c), {30'h0, p1_ack, p0_ack},
            ((c % 4) == 2) ? 32'h1 : 32'h2);
        chk($sformatf("cont%0d_do", c), p0_do | p1_do,
            ((c % 4) == 2) ? 32'h0000_0111 : 32'h0000_0222);
      end
    end
    idle_inputs();
    tick();
    chk("cont_end_idle", {29'h0, ram_en, p1_ack, p0_ack}, 32'h0);

    // Back-to-back single port: ack every 3 cycles, never twice in a row
    p0_req = 1; p0_a = 8'd1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("b2b%0d_ack", c), 32'(p0_ack), (c % 3 == 2) ? 32'h1 : 32'h0);
    end
    idle_inputs();
    tick();
    chk("b2b_end_ack", 32'(p0_ack), 32'h0);
    tick();
    chk("b2b_end_en", 32'(ram_en), 32'h0);

    // Reset during ACCESS aborts immediately; held p1 request served after release
    p0_req = 1; p0_a = 8'd5;
    tick();
    chk("mrst_pre_en", 32'(ram_en), 32'h1);
    RST_N = 1'b0;
    #1;
    chk("mrst_en", 32'(ram_en), 32'h0);
    chk("mrst_a", 32'(ram_a), 32'h0);
    chk("mrst_ack", {30'h0, p1_ack, p0_ack}, 32'h0);
    p0_req = 0;
    p1_req = 1; p1_we = 4'h0; p1_a = 8'd2;
    tick();
    chk("mrst_hold_ack", {29'h0, ram_en, p1_ack, p0_ack}, 32'h0);
    RST_N = 1'b1;
    tick();
    chk("mrst_rel_en", 32'(ram_en), 32'h1);
    chk("mrst_rel_a", 32'(ram_a), 32'd2);
    tick();
    chk("mrst_p1_ack", {30'h0, p1_ack, p0_ack}, 32'h2);
    chk("mrst_p1_do", p1_do, 32'h0000_0222);
    idle_inputs();
    tick();

    // p1 request pulsed between edges while p0 is served: never granted
    p0_req = 1; p0_a = 8'd1;
    tick();
    p1_req = 1; p1_a = 8'd2;
    #2;
    p1_req = 0;
    tick();
    chk("wd_p0_ack", {30'h0, p1_ack, p0_ack}, 32'h1);
    p0_req = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("wd%0d_p1", c), {p1_do[31:1], p1_do[0] | p1_ack}, 32'h0);
      chk($sformatf("wd%0d_en", c), 32'(ram_en), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
